// File: rtl/fetch_if.sv
// Fetch unit bus bundle: the controller-side request/branch signals, the
// memory read port and the instruction-register outputs.
// slave  = the fetch unit itself, master = the controller/memory side.
interface fetch_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16
);
  logic                 fetch_req;
  logic                 branch_en;
  logic [ADDR_BITS-1:0] branch_target;
  logic                 mem_ready;
  logic [WIDTH-1:0]     mem_rdata;
  logic                 mem_rd;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [WIDTH-1:0]     input_instruction;
  logic                 instruction_en;
  logic [ADDR_BITS-1:0] pc;
  logic                 busy;
  logic                 fetch_err;

  modport master (
    output fetch_req, branch_en, branch_target, mem_ready, mem_rdata,
    input  mem_rd, mem_addr, input_instruction, instruction_en, pc, busy,
    input  fetch_err
  );

  modport slave (
    input  fetch_req, branch_en, branch_target, mem_ready, mem_rdata,
    output mem_rd, mem_addr, input_instruction, instruction_en, pc, busy,
    output fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE -> REQ -> DONE handshake against a memory
// with a variable-latency ready. Captures one instruction word per request,
// advances pc (wrapping) or redirects it to a branch target.
// Optional feature: define FETCH_TIMEOUT_EN to abort a REQ that waits
// TIMEOUT cycles without mem_ready and raise the sticky fetch_err flag.
module fetch_unit #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT must be at least 1");
  end

  state_t               state;
  logic [ADDR_BITS-1:0] pc_q;
  logic [ADDR_BITS-1:0] pend_addr;
  logic                 pend_vld;
  logic                 mem_rd_q;
  logic                 instr_en_q;
  logic [WIDTH-1:0]     instr_q;
  logic [ADDR_BITS-1:0] capture_pc;

  // Address loaded into pc when an instruction is captured: a branch seen in
  // the capture cycle itself is the newest, then a pending one, else pc+1.
  always_comb begin
    capture_pc = pc_q + ADDR_ONE;
    if (bus.branch_en) begin
      capture_pc = bus.branch_target;
    end else if (pend_vld) begin
      capture_pc = pend_addr;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;
`endif

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pc_q       <= '0;
      pend_addr  <= '0;
      pend_vld   <= 1'b0;
      mem_rd_q   <= 1'b0;
      instr_en_q <= 1'b0;
      instr_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          instr_en_q <= 1'b0;
          // A branch here redirects pc at once, so a simultaneous fetch
          // already reads from the branch target.
          if (bus.branch_en) begin
            pc_q <= bus.branch_target;
          end
          if (bus.fetch_req) begin
            state    <= REQ;
            mem_rd_q <= 1'b1;
          end
        end

        REQ: begin
          if (bus.mem_ready) begin
            instr_q    <= bus.mem_rdata;
            pc_q       <= capture_pc;
            pend_vld   <= 1'b0;
            mem_rd_q   <= 1'b0;
            instr_en_q <= 1'b1;
            state      <= DONE;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end else begin
            // mem_addr must stay stable during the read, so a branch is
            // only remembered and applied when the read finishes.
            if (bus.branch_en) begin
              pend_addr <= bus.branch_target;
              pend_vld  <= 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            if (tmo_cnt == TMO_LAST) begin
              mem_rd_q <= 1'b0;
              err_q    <= 1'b1;
              pend_vld <= 1'b0;
              tmo_cnt  <= '0;
              state    <= IDLE;
            end else begin
              tmo_cnt  <= tmo_cnt + CNT_ONE;
            end
`endif
          end
        end

        DONE: begin
          instr_en_q <= 1'b0;
          state      <= IDLE;
          pend_vld   <= 1'b0;
          if (bus.branch_en) begin
            pc_q <= bus.branch_target;
          end else if (pend_vld) begin
            pc_q <= pend_addr;
          end
        end

        default: begin
          state      <= IDLE;
          mem_rd_q   <= 1'b0;
          instr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd            = mem_rd_q;
  assign bus.mem_addr          = pc_q;
  assign bus.pc                = pc_q;
  assign bus.input_instruction = instr_q;
  assign bus.instruction_en    = instr_en_q;
  assign bus.busy              = (state != IDLE);
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err         = err_q;
`else
  assign bus.fetch_err         = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus process pushes the expected
// {instruction, pc} for each fetch; a monitor pops and compares on every
// instruction_en pulse. Directed checks cover reset, wait states, wrap,
// branches in every state, ignored inputs, reset mid-read and (with
// FETCH_TIMEOUT_EN) the timeout abort.
module tb_fetch_unit;

  logic clk;
  logic reset;

  fetch_if #(.WIDTH(16), .ADDR_BITS(16)) bus ();

  fetch_unit #(.WIDTH(16), .ADDR_BITS(16), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every instruction_en pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && bus.instruction_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_instruction_en", 32'(bus.input_instruction), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instruction", 32'(bus.input_instruction), 32'(e.instr));
        check("sb_pc", 32'(bus.pc), 32'(e.pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode: 0 none, 1 branch with fetch_req in IDLE, 2 branch in first REQ
  // cycle, 3 branch in DONE cycle.
  task automatic do_fetch(input int delay, input logic [15:0] data,
                          input logic [15:0] addr, input logic [15:0] exp_pc,
                          input int mode, input logic [15:0] bt);
    bus.fetch_req = 1'b1;
    if (mode == 1) begin
      bus.branch_en     = 1'b1;
      bus.branch_target = bt;
    end
    tick();
    bus.fetch_req = 1'b0;
    bus.branch_en = 1'b0;
    if (mode == 2) begin
      bus.branch_en     = 1'b1;
      bus.branch_target = bt;
    end
    for (int i = 0; i < delay; i++) begin
      check("rd_wait", 32'(bus.mem_rd), 32'd1);
      check("addr_wait", 32'(bus.mem_addr), 32'(addr));
      check("busy_wait", 32'(bus.busy), 32'd1);
      tick();
      bus.branch_en = 1'b0;
    end
    check("rd_capture", 32'(bus.mem_rd), 32'd1);
    check("addr_capture", 32'(bus.mem_addr), 32'(addr));
    bus.mem_ready = 1'b1;
    bus.mem_rdata = data;
    sb.push_back('{instr: data, pc: exp_pc});
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h0000;
    bus.branch_en = 1'b0;
    // DONE cycle: a request here must be dropped
    bus.fetch_req = 1'b1;
    if (mode == 3) begin
      bus.branch_en     = 1'b1;
      bus.branch_target = bt;
    end
    check("rd_done", 32'(bus.mem_rd), 32'd0);
    check("busy_done", 32'(bus.busy), 32'd1);
    tick();
    bus.fetch_req = 1'b0;
    bus.branch_en = 1'b0;
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("rd_idle", 32'(bus.mem_rd), 32'd0);
    check("pc_final", 32'(bus.pc), (mode == 3) ? 32'(bt) : 32'(exp_pc));
  endtask

  task automatic branch_idle(input logic [15:0] bt);
    bus.branch_en     = 1'b1;
    bus.branch_target = bt;
    tick();
    bus.branch_en = 1'b0;
    check("pc_branch_idle", 32'(bus.pc), 32'(bt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset             = 1'b0;
    bus.fetch_req     = 1'b0;
    bus.branch_en     = 1'b0;
    bus.branch_target = 16'h0000;
    bus.mem_ready     = 1'b0;
    bus.mem_rdata     = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_instruction_en", 32'(bus.instruction_en), 32'd0);
    check("rst_instruction", 32'(bus.input_instruction), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
    reset = 1'b1;
    tick();

    // Minimum latency fetch, pc 0 -> 1
    do_fetch(0, 16'h1A23, 16'h0000, 16'h0001, 0, 16'h0000);
    // Five wait states, six REQ cycles
    do_fetch(5, 16'h2B34, 16'h0001, 16'h0002, 0, 16'h0000);
    // pc wrap from all-ones
    branch_idle(16'hFFFF);
    do_fetch(1, 16'h3C45, 16'hFFFF, 16'h0000, 0, 16'h0000);
    // Branch during REQ overrides pc+1
    do_fetch(2, 16'h4D56, 16'h0000, 16'h0040, 2, 16'h0040);
    // Branch with fetch_req in IDLE: read from target
    do_fetch(0, 16'h5E67, 16'h0100, 16'h0101, 1, 16'h0100);
    // Branch during DONE loads pc on the way back to IDLE
    do_fetch(0, 16'h6F78, 16'h0101, 16'h0102, 3, 16'h0200);

    // mem_ready in IDLE is ignored
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    tick();
    bus.mem_ready = 1'b0;
    check("idle_ready_busy", 32'(bus.busy), 32'd0);
    check("idle_ready_pc", 32'(bus.pc), 32'h0200);
    check("idle_ready_instr", 32'(bus.input_instruction), 32'h6F78);
    tick();

    // Reset in the middle of a read
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    check("midreq_rd", 32'(bus.mem_rd), 32'd1);
    reset = 1'b0;
    tick();
    check("midreset_rd", 32'(bus.mem_rd), 32'd0);
    check("midreset_pc", 32'(bus.pc), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_instruction_en", 32'(bus.instruction_en), 32'd0);
    check("midreset_instr", 32'(bus.input_instruction), 32'd0);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    tick();
    bus.mem_ready = 1'b0;
    check("postreset_busy", 32'(bus.busy), 32'd0);
    check("postreset_instr", 32'(bus.input_instruction), 32'd0);
    tick();

    // Normal fetch after the aborted one starts again from 0
    do_fetch(3, 16'h7A89, 16'h0000, 16'h0001, 0, 16'h0000);

`ifdef FETCH_TIMEOUT_EN
    branch_idle(16'h0030);
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("tmo_before_err", 32'(bus.fetch_err), 32'd0);
    check("tmo_before_busy", 32'(bus.busy), 32'd1);
    tick();
    check("tmo_err", 32'(bus.fetch_err), 32'd1);
    check("tmo_busy", 32'(bus.busy), 32'd0);
    check("tmo_rd", 32'(bus.mem_rd), 32'd0);
    check("tmo_pc", 32'(bus.pc), 32'h0030);
    repeat (3) tick();
    check("tmo_sticky", 32'(bus.fetch_err), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("tmo_cleared", 32'(bus.fetch_err), 32'd0);
    tick();
`else
    // Long wait with no timeout: still waiting, no error
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("notmo_busy", 32'(bus.busy), 32'd1);
    check("notmo_rd", 32'(bus.mem_rd), 32'd1);
    check("notmo_err", 32'(bus.fetch_err), 32'd0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h8B9A;
    sb.push_back('{instr: 16'h8B9A, pc: 16'h0002});
    tick();
    bus.mem_ready = 1'b0;
    tick();
`endif

    repeat (2) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 16, instruction and memory data width.
REQ-002 Parameter ADDR_BITS, default 16, program counter and memory address width.
REQ-003 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ready (used only with FETCH_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 fetch_req  input  1  controller request for the next instruction; sampled only in IDLE.
REQ-007 branch_en  input  1  load branch_target as the next fetch address.
REQ-008 branch_target  input  ADDR_BITS  branch destination address.
REQ-009 mem_ready  input  1  memory read data valid this cycle.
REQ-010 mem_rdata  input  WIDTH  memory read data.
REQ-011 mem_rd  output  1  memory read strobe, registered.
REQ-012 mem_addr  output  ADDR_BITS  memory read address, equals pc.
REQ-013 input_instruction  output  WIDTH  captured instruction word, held until next capture.
REQ-014 instruction_en  output  1  one-cycle load pulse for the instruction register.
REQ-015 pc  output  ADDR_BITS  current program counter.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, REQ, DONE, one-hot or binary at implementer's choice.
REQ-019 IDLE: fetch_req=1 -> REQ with mem_rd=1 from the next cycle; otherwise stay IDLE.
REQ-020 REQ: mem_rd SHALL stay 1 and mem_addr stable until the cycle mem_ready=1.
REQ-021 REQ with mem_ready=1: capture mem_rdata into input_instruction, update pc, mem_rd=0, go to DONE.
REQ-022 DONE: instruction_en=1 for exactly that one cycle, then IDLE unconditionally.
REQ-023 Minimum latency: fetch_req sampled at edge N with mem_ready=1 in cycle N+1 -> instruction_en high in cycle N+2.
REQ-024 pc update on capture SHALL be pc+1 modulo 2^ADDR_BITS (all-ones wraps to 0), unless a branch is pending.
REQ-025 branch_en in IDLE SHALL load pc=branch_target at that edge; with simultaneous fetch_req the fetch SHALL use branch_target.
REQ-026 branch_en in REQ or DONE SHALL latch branch_target into a pending register; the pending target overrides pc+1 (if captured in REQ) or loads pc on the DONE->IDLE edge; the latest branch_en wins.
REQ-027 fetch_req outside IDLE SHALL be ignored (no queuing).
REQ-028 mem_ready outside REQ SHALL be ignored.

Reset
REQ-029 reset=0 at a rising edge SHALL force state IDLE, pc=0, mem_rd=0, instruction_en=0, input_instruction=0, fetch_err=0, pending branch cleared, timeout counter=0, regardless of state.
REQ-030 Reset mid-REQ SHALL abort the read with no capture and no instruction_en pulse.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN defined: a counter increments each REQ cycle without mem_ready; reaching TIMEOUT -> mem_rd=0, fetch_err=1 (sticky until reset), state IDLE, pc unchanged, no instruction_en.
REQ-032 FETCH_TIMEOUT_EN undefined: REQ waits indefinitely; fetch_err tied to 0; no counter logic.

Verification
REQ-033 Reset, fetch_req pulse, mem_ready next cycle with mem_rdata=16'h1A23 -> instruction_en one cycle, input_instruction=16'h1A23, pc 0->1.
REQ-034 pc=16'hFFFF, one fetch completes -> pc=16'h0000.
REQ-035 branch_en with branch_target=16'h0040 during REQ, then mem_ready -> pc=16'h0040 after capture, not pc+1.
REQ-036 mem_ready delayed 5 cycles -> mem_rd high and mem_addr stable for all 6 REQ cycles; busy high throughout.
REQ-037 reset=0 asserted during REQ -> next cycle mem_rd=0, pc=0, no instruction_en pulse.
REQ-038 FETCH_TIMEOUT_EN, TIMEOUT=15, mem_ready never asserted -> fetch_err=1 after 15 REQ cycles, state IDLE, pc unchanged; flag remains 1 until reset.
